// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for timer_arbiter; the arbitration mode is chosen in
// timer_arbiter by TIMER_ARB_FIXED_PRIO_EN.
package timer_arb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned DEFAULT_TICKS_PER_UNIT = 200_000_000;
  localparam int unsigned MAX_REQ = 8;

  // One-hot of the first set bit strictly after ptr, searching circularly over n bits.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0] ptr,
                                                 input int unsigned n);
    logic [MAX_REQ-1:0] sel;
    logic [2:0] idx;
    sel = '0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if (i <= n && sel == '0 && req[idx]) sel[idx] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/timer_arbiter_unit_counter.sv
// Tick counter for one duration unit; pulses wrap on its last tick while enabled.
module unit_counter
  import timer_arb_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic wrap
);
  localparam int unsigned CW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_UNIT - 1);

  logic [CW-1:0] count_reg;

  assign wrap = enable && (count_reg == LAST);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= wrap ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one interval timer among NUM_REQ requesters; round-robin by default,
// fixed lowest-index priority when TIMER_ARB_FIXED_PRIO_EN is defined.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT,
  parameter int unsigned DUR_W          = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);
  localparam int unsigned IW = $clog2(NUM_REQ);

  state_t             state_reg;
  logic [IW-1:0]      win_reg;
  logic [IW-1:0]      ptr_reg;
  logic [IW-1:0]      pick_idx;
  logic [DUR_W-1:0]   units_left_reg;
  logic [DUR_W-1:0]   pick_dur;
  logic [DUR_W-1:0]   dur_field [NUM_REQ];
  logic [MAX_REQ-1:0] pick_onehot;
  logic [2:0]         search_ptr;
  logic               wrap;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dur
    assign dur_field[gi] = dur[gi*DUR_W +: DUR_W];
  end

`ifdef TIMER_ARB_FIXED_PRIO_EN
  // Searching after the last index makes index 0 the first candidate every time.
  assign search_ptr = 3'(NUM_REQ - 1);
`else
  assign search_ptr = 3'(ptr_reg);
`endif

  assign pick_onehot = rr_pick(MAX_REQ'(req), search_ptr, NUM_REQ);

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = IW'(i);
    end
  end

  assign pick_dur = dur_field[pick_idx];

  unit_counter #(.TICKS_PER_UNIT(TICKS_PER_UNIT)) u_unit_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (state_reg != RUN),
    .enable (state_reg == RUN),
    .wrap   (wrap)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      grant          <= '0;
      done           <= '0;
      busy           <= 1'b0;
      units_left_reg <= '0;
      win_reg        <= '0;
      ptr_reg        <= IW'(NUM_REQ - 1);
    end else begin
      done <= '0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg      <= RUN;
            win_reg        <= pick_idx;
            grant          <= NUM_REQ'(1) << pick_idx;
            busy           <= 1'b1;
            units_left_reg <= (pick_dur == '0) ? DUR_W'(1) : pick_dur;
          end
        end
        RUN: begin
          // A dropped request wins over a completion in the same cycle.
          if (!req[win_reg]) begin
            state_reg <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            ptr_reg   <= win_reg;
          end else if (wrap) begin
            units_left_reg <= units_left_reg - 1'b1;
            if (units_left_reg == DUR_W'(1)) begin
              state_reg <= DONE;
              grant     <= '0;
              done      <= grant;
              ptr_reg   <= win_reg;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          grant     <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter (TICKS_PER_UNIT=4); honours TIMER_ARB_FIXED_PRIO_EN.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [15:0] dur = 16'h0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  timer_arbiter #(.NUM_REQ(N), .TICKS_PER_UNIT(T), .DUR_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .dur(dur),
    .grant(grant), .done(done), .busy(busy)
  );

  initial forever #5 clock = ~clock;

  // Reference model: tracks the active interval by its completion cycle number.
  typedef struct {
    bit         valid;
    bit         active;
    bit         in_done;
    int         win;
    int         ptr;
    int         end_cyc;
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
  } mstate_t;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    string      name;
  } exp_t;

  mstate_t m = '{default: 0};
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  bit      finish_req = 1'b0;
  exp_t    exp_q[$];

  function automatic mstate_t model_next(input mstate_t s, input int n, input logic rst_n,
                                         input logic [3:0] r, input logic [15:0] du);
    mstate_t t;
    int start;
    int idx;
    int dd;
    bit found;
    t = s;
    t.g = 4'b0;
    t.d = 4'b0;
    t.b = 1'b0;
    if (!rst_n) begin
      t.valid = 1'b1;
      t.active = 1'b0;
      t.in_done = 1'b0;
      t.ptr = N - 1;
    end else if (!t.valid) begin
      t.valid = 1'b0;
    end else if (t.in_done) begin
      t.in_done = 1'b0;
    end else if (t.active) begin
      if (!r[t.win]) begin
        t.active = 1'b0;
        t.ptr = t.win;
      end else if (n == t.end_cyc) begin
        t.active = 1'b0;
        t.in_done = 1'b1;
        t.ptr = t.win;
        t.d = 4'(1 << t.win);
        t.b = 1'b1;
      end else begin
        t.g = 4'(1 << t.win);
        t.b = 1'b1;
      end
    end else if (r != 4'b0) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
      start = N - 1;
`else
      start = t.ptr;
`endif
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (start + k) % N;
        if (!found && r[idx]) begin
          found = 1'b1;
          t.win = idx;
        end
      end
      dd = int'(du[t.win*4 +: 4]);
      if (dd == 0) dd = 1;
      t.active = 1'b1;
      t.end_cyc = n + dd * T;
      t.g = 4'(1 << t.win);
      t.b = 1'b1;
    end
    return t;
  endfunction

  initial forever begin
    @(posedge clock);
    m = model_next(m, cyc + 1, reset_n, req, dur);
    cyc = cyc + 1;
  end

  // Single checker: model comparison every cycle plus queued literal expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (m.valid) begin
        checks++;
        if (grant !== m.g) begin
          errors++;
          $display("FAIL model_grant cycle %0d: got %b expected %b", cyc, grant, m.g);
        end
        checks++;
        if (done !== m.d) begin
          errors++;
          $display("FAIL model_done cycle %0d: got %b expected %b", cyc, done, m.d);
        end
        checks++;
        if (busy !== m.b) begin
          errors++;
          $display("FAIL model_busy cycle %0d: got %b expected %b", cyc, busy, m.b);
        end
        if (done != 4'b0) $display("cycle %0d: done=%b", cyc, done);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc || grant !== e.g || done !== e.d || busy !== e.b) begin
          errors++;
          $display("FAIL %s cycle %0d: got grant=%b done=%b busy=%b expected grant=%b done=%b busy=%b at cycle %0d",
                   e.name, cyc, grant, done, busy, e.g, e.d, e.b, e.cyc);
        end
      end
      if (finish_req || cyc > 60000) begin
        if (!finish_req) begin
          errors++;
          $display("FAIL watchdog: got cycle %0d expected end before 60000", cyc);
        end
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending_expectations: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic expect_at(input int c, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input string nm);
    exp_t e;
    e.cyc = c;
    e.g = g;
    e.d = d;
    e.b = b;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_k(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req = 4'b0;
    dur = 16'h0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    int bi;
    // Single request, dur 3
    do_reset();
    base = cyc;
    req = 4'b0001;
    dur = 16'h0003;
    expect_at(base + 1,  4'b0001, 4'b0000, 1'b1, "t1_grant_rise");
    expect_at(base + 12, 4'b0001, 4'b0000, 1'b1, "t1_grant_last");
    expect_at(base + 13, 4'b0000, 4'b0001, 1'b1, "t1_done");
    expect_at(base + 14, 4'b0000, 4'b0000, 1'b0, "t1_idle");
    wait_k(base + 13);
    req = 4'b0;
    wait_k(base + 16);

`ifdef TIMER_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 keeps winning
    do_reset();
    base = cyc;
    req = 4'b0011;
    dur = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      expect_at(base + 1 + 6 * i, 4'b0001, 4'b0000, 1'b1, "t6_grant");
      expect_at(base + 5 + 6 * i, 4'b0000, 4'b0001, 1'b1, "t6_done");
    end
    wait_k(base + 17);
    req = 4'b0;
    wait_k(base + 20);
`else
    // Round-robin over four held requests
    do_reset();
    base = cyc;
    req = 4'b1111;
    dur = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      expect_at(base + 1 + 6 * i, 4'(1 << (i % 4)), 4'b0000, 1'b1, "t2_grant");
      expect_at(base + 5 + 6 * i, 4'b0000, 4'(1 << (i % 4)), 1'b1, "t2_done");
    end
    wait_k(base + 29);
    req = 4'b0;
    wait_k(base + 32);
`endif

    // Abort, then pointer-driven search
    do_reset();
    base = cyc;
    req = 4'b0100;
    dur = 16'h0500;
    expect_at(base + 1,  4'b0100, 4'b0000, 1'b1, "t3_grant");
    expect_at(base + 8,  4'b0000, 4'b0000, 1'b0, "t3_abort");
    expect_at(base + 9,  4'b0010, 4'b0000, 1'b1, "t3_regrant");
    expect_at(base + 13, 4'b0000, 4'b0010, 1'b1, "t3_done");
    wait_k(base + 7);
    req = 4'b0000;
    wait_k(base + 8);
    req = 4'b0110;
    wait_k(base + 13);
    req = 4'b0;
    wait_k(base + 16);

    // Zero duration counts as one unit
    do_reset();
    base = cyc;
    req = 4'b1000;
    dur = 16'h0000;
    expect_at(base + 1, 4'b1000, 4'b0000, 1'b1, "t4_grant");
    expect_at(base + 4, 4'b1000, 4'b0000, 1'b1, "t4_grant_last");
    expect_at(base + 5, 4'b0000, 4'b1000, 1'b1, "t4_done");
    expect_at(base + 6, 4'b0000, 4'b0000, 1'b0, "t4_idle");
    wait_k(base + 5);
    req = 4'b0;
    wait_k(base + 8);

    // Reset in the middle of RUN
    do_reset();
    base = cyc;
    req = 4'b0001;
    dur = 16'h0002;
    expect_at(base + 1,  4'b0001, 4'b0000, 1'b1, "t5_grant");
    expect_at(base + 5,  4'b0001, 4'b0000, 1'b1, "t5_pre_reset");
    expect_at(base + 6,  4'b0000, 4'b0000, 1'b0, "t5_reset");
    expect_at(base + 7,  4'b0001, 4'b0000, 1'b1, "t5_regrant");
    expect_at(base + 9,  4'b0001, 4'b0000, 1'b1, "t5_no_old_done");
    expect_at(base + 14, 4'b0001, 4'b0000, 1'b1, "t5_grant_last");
    expect_at(base + 15, 4'b0000, 4'b0001, 1'b1, "t5_done");
    wait_k(base + 5);
    reset_n = 1'b0;
    wait_k(base + 6);
    reset_n = 1'b1;
    wait_k(base + 15);
    req = 4'b0;
    wait_k(base + 18);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 19) == 0) begin
        bi = int'($urandom_range(0, 3));
        req[bi] = ~req[bi];
      end
      if ($urandom_range(0, 31) == 0) dur = 16'($urandom);
      reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clock);
    req = 4'b0;
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    finish_req = 1'b1;
  end

endmodule
